// File: rtl/kbd_port_pkg.sv
// Shared field offsets and register bit indices for the PS/2 keyboard I/O port.
// Pure definitions: no latency, no backpressure.
// Any block decoding ps2 event words or kbd_port status/control bytes imports this.
package kbd_port_pkg;

    localparam int ENTRY_W      = 10;

    // ps2 event word fields
    localparam int KEY_TOG      = 10;
    localparam int KEY_PRS      = 9;
    localparam int KEY_EXT      = 8;
    localparam int KEY_CODE_LSB = 0;

    // status byte bits
    localparam int ST_NEMPTY    = 0;
    localparam int ST_PRESSED   = 1;
    localparam int ST_EXT       = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_FULL      = 4;
    localparam int ST_IRQEN     = 5;

    // control byte bits
    localparam int CT_FLUSH     = 0;
    localparam int CT_CLROVF    = 1;
    localparam int CT_IRQEN     = 2;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } key_ent_t;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with flush; head is combinational from the read pointer.
// Latency: push visible in count/head on the next clk; pop likewise.
// Backpressure: push while full is dropped unless a pop frees the slot that cycle; flush wins.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/kbd_port.sv
// Z80 I/O front end for PS/2 key events: data port at PORT_BASE, status/control at PORT_BASE+1.
// Latency: one clk for dout/sel/irq_n; pop happens the clk after the data read strobe ends.
// Backpressure: none toward ps2; events arriving while full are dropped and flag overflow. KBD_PORT_IRQ_EN enables irq.
module kbd_port
    import kbd_port_pkg::*;
#(
    parameter logic [7:0] PORT_BASE  = 8'h82,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  addr,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_m1,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        sel,
    output logic        irq_n,
    output logic [3:0]  count
);

    localparam logic [7:0] STAT_ADDR = PORT_BASE + 8'd1;
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

    logic          data_sel, stat_sel;
    logic          data_rd_now, stat_rd_now, stat_wr_now;
    logic          rd_data_q, wr_stat_q, wr_stat_q2;
    logic          prev, armed, ovf, irq_en;
    logic [2:0]    ctl_q;
    logic          push_req, pop_req, flush, ctl_fire, drop;
    logic          empty, full;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    status;
    key_ent_t      push_ent, head;

    assign data_sel    = (addr == PORT_BASE) && !n_iorq && n_m1;
    assign stat_sel    = (addr == STAT_ADDR) && !n_iorq && n_m1;
    assign data_rd_now = data_sel && !n_rd;
    assign stat_rd_now = stat_sel && !n_rd;
    assign stat_wr_now = stat_sel && !n_wr;

    assign push_req = armed && (ps2_key[KEY_TOG] != prev);
    // pop at the trailing edge of the read so dout stays stable for the whole strobe
    assign pop_req  = rd_data_q && !data_rd_now && !empty;
    assign ctl_fire = wr_stat_q && !wr_stat_q2;
    assign flush    = ctl_fire && ctl_q[CT_FLUSH];
    assign drop     = push_req && full && !pop_req && !flush;
    assign push_ent = '{pressed: ps2_key[KEY_PRS], ext: ps2_key[KEY_EXT],
                        code: ps2_key[KEY_CODE_LSB +: 8]};
    assign count    = 4'(fifo_cnt);

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_req),
        .push_dat (push_ent),
        .pop      (pop_req),
        .flush    (flush),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .count    (fifo_cnt)
    );

    always_comb begin
        status             = '0;
        status[ST_NEMPTY]  = !empty;
        status[ST_PRESSED] = !empty && head.pressed;
        status[ST_EXT]     = !empty && head.ext;
        status[ST_OVF]     = ovf;
        status[ST_FULL]    = full;
        status[ST_IRQEN]   = irq_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= 1'b0;
            armed      <= 1'b0;
            rd_data_q  <= 1'b0;
            wr_stat_q  <= 1'b0;
            wr_stat_q2 <= 1'b0;
            ctl_q      <= '0;
            ovf        <= 1'b0;
            dout       <= 8'h00;
            sel        <= 1'b0;
        end else begin
            prev       <= ps2_key[KEY_TOG];
            armed      <= 1'b1;
            rd_data_q  <= data_rd_now;
            wr_stat_q  <= stat_wr_now;
            wr_stat_q2 <= wr_stat_q;
            if (stat_wr_now) ctl_q <= din[CT_IRQEN:0];
            // a drop in the same cycle as clear-overflow keeps the flag set
            if (drop)                              ovf <= 1'b1;
            else if (ctl_fire && ctl_q[CT_CLROVF]) ovf <= 1'b0;
            sel <= data_rd_now || stat_rd_now;
            if (data_rd_now)      dout <= empty ? 8'h00 : head.code;
            else if (stat_rd_now) dout <= status;
            else                  dout <= 8'h00;
        end
    end

`ifdef KBD_PORT_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq_n  <= 1'b1;
        end else begin
            if (ctl_fire) irq_en <= ctl_q[CT_IRQEN];
            irq_n <= !(irq_en && !empty);
        end
    end
`else
    logic unused_ctl_irqen;
    assign unused_ctl_irqen = ctl_q[CT_IRQEN];
    assign irq_en = 1'b0;
    assign irq_n  = 1'b1;
`endif

    logic unused_din;
    assign unused_din = &{1'b0, din[7:CT_IRQEN+1]};

endmodule

// File: tb/tb_kbd_port.sv
// Directed + randomized bench for kbd_port against a queue-based model of the key FIFO.
// Honours KBD_PORT_IRQ_EN the same way the design does.
module tb_kbd_port;

    localparam logic [7:0] PB    = 8'h82;
    localparam logic [7:0] PS    = 8'h83;
    localparam int         DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [7:0]  addr;
    logic        n_iorq, n_rd, n_wr, n_m1;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        sel;
    logic        irq_n;
    logic [3:0]  count;

    kbd_port #(.PORT_BASE(PB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .addr    (addr),
        .n_iorq  (n_iorq),
        .n_rd    (n_rd),
        .n_wr    (n_wr),
        .n_m1    (n_m1),
        .din     (din),
        .dout    (dout),
        .sel     (sel),
        .irq_n   (irq_n),
        .count   (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [9:0] q[$];
    bit         ovf_m;
    bit         ien_m;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = 8'h00;
        if (q.size() > 0) begin
            s[0] = 1'b1;
            s[1] = q[0][9];
            s[2] = q[0][8];
        end
        s[3] = ovf_m;
        s[4] = (q.size() == DEPTH);
        s[5] = ien_m;
        return s;
    endfunction

    function automatic logic exp_irq_n();
`ifdef KBD_PORT_IRQ_EN
        return !(ien_m && q.size() > 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_push(input logic [9:0] e);
        if (q.size() == DEPTH) ovf_m = 1'b1;
        else                   q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle(input logic [9:0] e);
        ps2_key = {~ps2_key[10], e};
    endtask

    task automatic check_idle();
        chk("count", 16'(count), 16'(q.size()));
        chk("irq_n", 16'(irq_n), 16'(exp_irq_n()));
    endtask

    task automatic send_event(input logic [9:0] e);
        toggle(e);
        tick();
        model_push(e);
        chk("cnt_push", 16'(count), 16'(q.size()));
        tick();
    endtask

    // CPU read of three clocks; optionally a key event lands on the pop edge
    task automatic io_read(input logic [7:0] a, input bit m1_cycle, input bit ev_en,
                           input logic [9:0] e, output logic [7:0] d);
        logic [7:0] exp;
        addr   = a;
        n_m1   = !m1_cycle;
        n_iorq = 1'b0;
        n_rd   = 1'b0;
        repeat (3) tick();
        d = dout;
        if (!m1_cycle && a == PB)      exp = (q.size() > 0) ? q[0][7:0] : 8'h00;
        else if (!m1_cycle && a == PS) exp = exp_status();
        else                           exp = 8'h00;
        chk((a == PS) ? "rd_stat" : "rd_data", 16'(d), 16'(exp));
        chk("sel", 16'(sel), 16'(!m1_cycle && (a == PB || a == PS)));
        n_iorq = 1'b1;
        n_rd   = 1'b1;
        n_m1   = 1'b1;
        if (ev_en) toggle(e);
        tick();
        if (!m1_cycle && a == PB && q.size() > 0) void'(q.pop_front());
        if (ev_en) model_push(e);
        tick();
    endtask

    // CPU write of three clocks; optionally a key event lands on the control-action edge
    task automatic io_write(input logic [7:0] a, input logic [7:0] v, input bit ev_en,
                            input logic [9:0] e);
        addr   = a;
        din    = v;
        n_iorq = 1'b0;
        n_wr   = 1'b0;
        tick();
        if (ev_en) toggle(e);
        tick();
        tick();
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        tick();
        tick();
        if (a == PS) begin
            if (v[0]) q.delete();
            if (v[1]) ovf_m = 1'b0;
`ifdef KBD_PORT_IRQ_EN
            ien_m = v[2];
`endif
        end
        if (ev_en && !(a == PS && v[0])) model_push(e);
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] e;
        int         op;

        reset_n = 1'b0;
        ps2_key = 11'h400;
        addr    = 8'h00;
        n_iorq  = 1'b1;
        n_rd    = 1'b1;
        n_wr    = 1'b1;
        n_m1    = 1'b1;
        din     = 8'h00;
        ovf_m   = 1'b0;
        ien_m   = 1'b0;
        repeat (3) tick();
        chk("rst_dout", 16'(dout), 16'h0);
        chk("rst_sel", 16'(sel), 16'h0);
        chk("rst_irq", 16'(irq_n), 16'h1);
        chk("rst_cnt", 16'(count), 16'h0);

        // toggle bit held high through release must not create an event
        reset_n = 1'b1;
        repeat (5) tick();
        check_idle();

        // single pressed event
        send_event({1'b1, 1'b0, 8'h1C});
        check_idle();
        io_read(PS, 1'b0, 1'b0, 10'h0, d);
        chk("st_bits", 16'(d[2:0]), 16'h3);
        io_read(PB, 1'b0, 1'b0, 10'h0, d);
        chk("code_1c", 16'(d), 16'h1C);
        check_idle();

        // overflow: nine events into eight slots
        for (int i = 0; i < 9; i++) send_event({2'b00, 8'(8'h30 + i)});
        io_read(PS, 1'b0, 1'b0, 10'h0, d);
        chk("st_ovf_full", 16'(d), 16'h19);
        for (int i = 0; i < 8; i++) begin
            io_read(PB, 1'b0, 1'b0, 10'h0, d);
            chk("ovf_order", 16'(d), 16'(8'h30 + i));
        end
        io_read(PB, 1'b0, 1'b0, 10'h0, d);
        chk("empty_data", 16'(d), 16'h0);
        io_write(PS, 8'h02, 1'b0, 10'h0);
        io_read(PS, 1'b0, 1'b0, 10'h0, d);
        chk("ovf_clr", 16'(d), 16'h0);

        // simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) send_event({2'b01, 8'(8'h50 + i)});
        io_read(PB, 1'b0, 1'b1, {2'b10, 8'h5F}, d);
        check_idle();
        chk("pp_cnt3", 16'(count), 16'h3);
        while (q.size() > 0) io_read(PB, 1'b0, 1'b0, 10'h0, d);

        // flush coincident with a push
        send_event(10'h011);
        send_event(10'h022);
        io_write(PS, 8'h01, 1'b1, 10'h033);
        chk("flush_cnt", 16'(count), 16'h0);
        check_idle();

        // interrupt enable, M1 cycle ignored, data read releases irq
        io_write(PS, 8'h04, 1'b0, 10'h0);
        toggle(10'h1AA);
        tick();
        chk("irq_lat1", 16'(irq_n), 16'h1);
        model_push(10'h1AA);
        tick();
        chk("irq_lat2", 16'(irq_n), 16'(exp_irq_n()));
        io_read(PB, 1'b1, 1'b0, 10'h0, d);
        check_idle();
        io_write(PB, 8'h03, 1'b0, 10'h0);
        check_idle();
        io_read(PB, 1'b0, 1'b0, 10'h0, d);
        check_idle();
        chk("irq_rel", 16'(irq_n), 16'h1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 5);
            e  = 10'($urandom_range(0, 1023));
            case (op)
                0, 1: send_event(e);
                2:    io_read(PB, 1'b0, 1'b0, 10'h0, d);
                3:    io_read(PS, 1'b0, 1'b0, 10'h0, d);
                4:    io_write(PS, {5'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 7) == 0)}, 1'b0, 10'h0);
                default: io_read(PB, 1'b0, 1'b1, e, d);
            endcase
            check_idle();
        end

        // reset in the middle of a data read
        if (q.size() == 0) send_event(10'h2C3);
        addr   = PB;
        n_iorq = 1'b0;
        n_rd   = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 16'(count), 16'h0);
        chk("mid_rst_sel", 16'(sel), 16'h0);
        chk("mid_rst_dout", 16'(dout), 16'h0);
        n_iorq = 1'b1;
        n_rd   = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        ien_m = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_idle();
        io_read(PS, 1'b0, 1'b0, 10'h0, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
